// File: rtl/adc_frame_packer.sv
// Decimating averager feeding a byte-framed packetizer for the UART TX FIFO.
// Frame: HEADER, seq, {hi,lo} per averaged sample, XOR checksum of all preceding bytes.
module adc_frame_packer #(
  parameter int          DECIM_LOG2 = 4,
  parameter int          N_SAMPLES  = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_i,
  input  logic        sample_valid_i,
  input  logic        sample_error_i,
  input  logic        fifo_full_i,
  output logic [7:0]  byte_o,
  output logic        byte_wr_o,
  output logic        busy_o,
  output logic [15:0] drop_cnt_o,
  output logic        adc_err_o
);
  localparam int AW = 12 + DECIM_LOG2;
  localparam int DW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [DW-1:0] DLAST    = DW'((1 << DECIM_LOG2) - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, SHI, SLO, CHK} state_t;
  state_t state, state_d;

  logic [AW-1:0] acc, sum;
  logic [DW-1:0] dcnt;
  logic [IW-1:0] idx, k;
  logic [11:0]   avg;
  logic [11:0]   buffer [N_SAMPLES];
  logic [11:0]   shadow [N_SAMPLES];
  logic [7:0]    seq, chk;
  logic          accept, last_dec, handoff, start;

  assign accept   = sample_valid_i & ~sample_error_i;
  assign last_dec = accept & (dcnt == DLAST);
  assign sum      = acc + AW'(sample_i);
  assign avg      = sum[DECIM_LOG2 +: 12];
  assign handoff  = last_dec & (idx == IDX_LAST);
  assign start    = handoff & (state == IDLE);

  assign busy_o    = (state != IDLE);
  assign byte_wr_o = busy_o & ~fifo_full_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      dcnt       <= '0;
      idx        <= '0;
      drop_cnt_o <= '0;
      adc_err_o  <= 1'b0;
    end else begin
      if (sample_valid_i & sample_error_i) adc_err_o <= 1'b1;
      if (last_dec) begin
        acc  <= '0;
        dcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (accept) begin
        acc  <= sum;
        dcnt <= dcnt + 1'b1;
      end
      // A frame completing while the previous one is still in flight is lost.
      if (handoff && state != IDLE && drop_cnt_o != 16'hFFFF)
        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Sample storage carries no reset; contents are only consumed after a handoff.
  always_ff @(posedge clk) begin
    if (last_dec) buffer[idx] <= avg;
    if (start)
      for (int i = 0; i < N_SAMPLES; i++)
        shadow[i] <= (i == N_SAMPLES - 1) ? avg : buffer[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      seq   <= '0;
      chk   <= '0;
    end else begin
      state <= state_d;
      if (start) begin
        k   <= '0;
        chk <= '0;
      end else if (byte_wr_o) begin
        chk <= chk ^ byte_o;
        if (state == SLO && k != IDX_LAST) k <= k + 1'b1;
        if (state == CHK) seq <= seq + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state;
    byte_o  = 8'h00;
    case (state)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        byte_o = HEADER;
        if (byte_wr_o) state_d = SEQ;
      end
      SEQ: begin
        byte_o = seq;
        if (byte_wr_o) state_d = SHI;
      end
      SHI: begin
        byte_o = {4'h0, shadow[k][11:8]};
        if (byte_wr_o) state_d = SLO;
      end
      SLO: begin
        byte_o = shadow[k][7:0];
        if (byte_wr_o) state_d = (k == IDX_LAST) ? CHK : SHI;
      end
      CHK: begin
        byte_o = chk;
        if (byte_wr_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomized bench for adc_frame_packer (DECIM_LOG2=2, N_SAMPLES=2) against a
// queue-based frame model built from the averaging and framing rules.
module tb_adc_frame_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample_i;
  logic        sample_valid_i, sample_error_i, fifo_full_i;
  logic [7:0]  byte_o;
  logic        byte_wr_o, busy_o, adc_err_o;
  logic [15:0] drop_cnt_o;

  adc_frame_packer #(.DECIM_LOG2(2), .N_SAMPLES(2), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_error_i(sample_error_i), .fifo_full_i(fifo_full_i), .byte_o(byte_o),
    .byte_wr_o(byte_wr_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o), .adc_err_o(adc_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got[$];
  int         stamp[$];
  always @(negedge clk) if (byte_wr_o) begin
    got.push_back(byte_o);
    stamp.push_back(cyc);
  end

  int passed = 0, total = 0;
  logic [7:0] gold [7] = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h01, 8'h05, 8'hA1};

  // Reference model: 4 accepted samples -> one average, 2 averages -> one frame.
  int         msum, mcnt;
  logic [11:0] mbuf[$];
  logic [7:0] mseq;
  bit         mdrop;
  logic [7:0] exp_q[$];

  task automatic model_clear();
    msum = 0; mcnt = 0; mbuf.delete(); mseq = 8'h00; mdrop = 0; exp_q.delete();
  endtask

  task automatic model_sample(input logic [11:0] s, input bit e);
    logic [7:0] fr[$];
    logic [7:0] x;
    if (e) return;
    msum += int'(s);
    mcnt++;
    if (mcnt == 4) begin
      mbuf.push_back(12'(msum / 4));
      msum = 0; mcnt = 0;
    end
    if (mbuf.size() == 2) begin
      if (!mdrop) begin
        fr.push_back(8'hA5);
        fr.push_back(mseq);
        foreach (mbuf[i]) begin
          fr.push_back({4'h0, mbuf[i][11:8]});
          fr.push_back(mbuf[i][7:0]);
        end
        x = 8'h00;
        foreach (fr[i]) x ^= fr[i];
        fr.push_back(x);
        foreach (fr[i]) exp_q.push_back(fr[i]);
        mseq++;
      end
      mbuf.delete();
    end
  endtask

  task automatic send(input logic [11:0] s, input bit e);
    sample_i = s; sample_valid_i = 1'b1; sample_error_i = e;
    model_sample(s, e);
    @(posedge clk); #1;
    sample_valid_i = 1'b0; sample_error_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_full_i = 1'b0; sample_valid_i = 1'b0; sample_error_i = 1'b0; sample_i = '0;
    idle(2);
    rst = 1'b0;
    model_clear();
    got.delete(); stamp.delete();
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (got.size() >= exp_q.size() && !busy_o) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_full_i = 1'b0; sample_valid_i = 1'b0; sample_error_i = 1'b0; sample_i = '0;
    #1;
    total++; if (byte_wr_o !== 1'b0) $display("FAIL reset_wr got %b want 0", byte_wr_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else passed++;
    idle(2);
    rst = 1'b0;
    idle(1);
    total++; if (byte_o !== 8'h00) $display("FAIL reset_byte got %h want 00", byte_o); else passed++;
    total++; if (drop_cnt_o !== 16'h0) $display("FAIL reset_drop got %h want 0", drop_cnt_o); else passed++;
    total++; if (adc_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", adc_err_o); else passed++;
    model_clear(); got.delete(); stamp.delete();
  endtask

  task automatic test_basic();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) send(12'h100 + 12'(i), 1'b0);
    wait_drain(50);
    total++; if (got.size() != 7) $display("FAIL basic_len got %0d want 7", got.size()); else passed++;
    bad = 0;
    for (int i = 0; i < 7 && i < got.size(); i++) if (got[i] !== gold[i]) begin
      bad++; $display("FAIL basic_byte[%0d] got %h want %h", i, got[i], gold[i]);
    end
    total++; if (bad != 0) $display("FAIL basic_bytes %0d wrong", bad); else passed++;
    bad = 0;
    for (int i = 1; i < stamp.size(); i++) if (stamp[i] != stamp[i-1] + 1) bad++;
    total++; if (bad != 0) $display("FAIL basic_consecutive got %0d gaps want 0", bad); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) send(12'h100 + 12'(i), 1'b0);
    for (int i = 0; i < 20 && got.size() < 2; i++) idle(1);
    fifo_full_i = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (byte_wr_o !== 1'b0 || byte_o !== 8'h01) begin
        bad++; $display("FAIL stall_hold wr %b byte %h want wr 0 byte 01", byte_wr_o, byte_o);
      end
      @(posedge clk); #1;
    end
    total++; if (bad != 0) $display("FAIL bp_stall %0d bad cycles", bad); else passed++;
    fifo_full_i = 1'b0;
    wait_drain(50);
    idle(5);
    total++; if (got.size() != 7) $display("FAIL bp_len got %0d want 7", got.size()); else passed++;
    bad = 0;
    for (int i = 0; i < 7 && i < got.size(); i++) if (got[i] !== gold[i]) bad++;
    total++; if (bad != 0) $display("FAIL bp_bytes %0d wrong of 7", bad); else passed++;
  endtask

  task automatic test_drop();
    int bad;
    do_reset();
    fifo_full_i = 1'b1;
    for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    mdrop = 1;
    for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    mdrop = 0;
    total++; if (drop_cnt_o !== 16'd1) $display("FAIL drop_cnt got %0d want 1", drop_cnt_o); else passed++;
    total++; if (got.size() != 0) $display("FAIL drop_nowr got %0d bytes want 0", got.size()); else passed++;
    fifo_full_i = 1'b0;
    wait_drain(50);
    idle(20);
    total++; if (got.size() != 7) $display("FAIL drop_len got %0d want 7", got.size()); else passed++;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (bad != 0 || got.size() < 2 || got[1] !== 8'h00)
      $display("FAIL drop_bytes %0d wrong, want seq 00 frame", bad); else passed++;
  endtask

  task automatic test_error();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(12'hFFF, 1'b1);
      send(12'h100 + 12'(i), 1'b0);
    end
    wait_drain(50);
    total++; if (got.size() != 7) $display("FAIL err_len got %0d want 7", got.size()); else passed++;
    bad = 0;
    for (int i = 0; i < 7 && i < got.size(); i++) if (got[i] !== gold[i]) bad++;
    total++; if (bad != 0) $display("FAIL err_bytes %0d wrong of 7", bad); else passed++;
    total++; if (adc_err_o !== 1'b1) $display("FAIL err_flag got %b want 1", adc_err_o); else passed++;
    for (int i = 0; i < 6; i++) send(12'(i), 1'b0);
    idle(10);
    total++; if (adc_err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", adc_err_o); else passed++;
  endtask

  task automatic test_random();
    int bad;
    bit any_err;
    do_reset();
    any_err = 0;
    while (exp_q.size() < 4 * 7) begin
      bit e;
      e = ($urandom_range(0, 4) == 0);
      any_err |= e;
      send(12'($urandom_range(0, 4095)), e);
      idle($urandom_range(0, 2));
    end
    wait_drain(100);
    total++; if (got.size() != exp_q.size()) $display("FAIL rand_len got %0d want %0d", got.size(), exp_q.size()); else passed++;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) begin
      if (bad < 5) $display("FAIL rand_byte[%0d] got %h want %h", i, got[i], exp_q[i]);
      bad++;
    end
    total++; if (bad != 0) $display("FAIL rand_bytes %0d wrong", bad); else passed++;
    total++; if (adc_err_o !== any_err) $display("FAIL rand_err got %b want %b", adc_err_o, any_err); else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    send(12'hFFF, 1'b0);
    send(12'hFFF, 1'b0);
    for (int i = 0; i < 20 && got.size() < 3; i++) idle(1);
    rst = 1'b1;
    #1;
    total++; if (byte_wr_o !== 1'b0 || busy_o !== 1'b0 || byte_o !== 8'h00 || drop_cnt_o !== 16'h0 || adc_err_o !== 1'b0)
      $display("FAIL rstmid_outs wr %b busy %b byte %h drop %h err %b want all 0",
               byte_wr_o, busy_o, byte_o, drop_cnt_o, adc_err_o);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(); got.delete(); stamp.delete();
    idle(3);
    total++; if (got.size() != 0) $display("FAIL rstmid_nowr got %0d bytes want 0", got.size()); else passed++;
    for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    wait_drain(50);
    total++; if (got.size() != 7) $display("FAIL rstmid_len got %0d want 7", got.size()); else passed++;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    total++; if (bad != 0) $display("FAIL rstmid_bytes %0d wrong of 7", bad); else passed++;
  endtask

  task automatic test_seq_wrap();
    int bad, sbad;
    do_reset();
    for (int f = 0; f < 257; f++)
      for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    wait_drain(100);
    total++; if (got.size() != 257 * 7) $display("FAIL wrap_len got %0d want %0d", got.size(), 257 * 7); else passed++;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) begin
      if (bad < 5) $display("FAIL wrap_byte[%0d] got %h want %h", i, got[i], exp_q[i]);
      bad++;
    end
    total++; if (bad != 0) $display("FAIL wrap_bytes %0d wrong", bad); else passed++;
    sbad = 0;
    for (int f = 0; f < 257 && f * 7 + 1 < got.size(); f++) begin
      logic [7:0] want;
      want = 8'(f % 256);
      if (got[f * 7 + 1] !== want) sbad++;
    end
    total++; if (sbad != 0) $display("FAIL wrap_seq %0d frames with wrong seq", sbad); else passed++;
    total++; if (drop_cnt_o !== 16'h0) $display("FAIL wrap_drop got %0d want 0", drop_cnt_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_error();
    test_random();
    test_reset_mid();
    test_seq_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
